// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding load/store memory target with programmable wait states.
module data_mem_responder #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int LATENCY = 2
) (
    input  logic                      CLK,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDRESS_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err,
    output logic [DATA_WIDTH/2-1:0]   testValue
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_n;
    logic [3:0] cnt;
    logic a_write;
    logic [ADDRESS_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDRESS_WIDTH-1:0] widx;
    logic [IW-1:0] wi;
    logic err;
    // full-width index compare so high address bits can never alias into range
    assign widx = {2'b00, a_addr[ADDRESS_WIDTH-1:2]};
    assign err = (a_addr[1:0] != 2'b00) || (widx >= ADDRESS_WIDTH'(DEPTH));
    assign wi = widx[IW-1:0];
    assign req_ready = rst && (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign testValue = mem[0][DATA_WIDTH/2-1:0];
    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = req_valid ? WAIT : IDLE;
            WAIT: state_n = (cnt == 4'd0) ? RESP : WAIT;
            RESP: state_n = rsp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt <= 4'd0;
            a_write <= 1'b0;
            a_addr <= '0;
            a_wdata <= '0;
            rsp_rdata <= '0;
            rsp_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && req_valid) begin
                a_write <= req_write;
                a_addr <= req_addr;
                a_wdata <= req_wdata;
                cnt <= 4'(LATENCY);
            end
            if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
            if (state == WAIT && cnt == 4'd0) begin
                rsp_err <= err;
                rsp_rdata <= (err || a_write) ? '0 : mem[wi];
                if (!err && a_write) mem[wi] <= a_wdata;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench with random traffic against a word-array reference model.
module tb_data_mem_responder;
    localparam int LAT = 2;
    typedef struct {logic [31:0] rdata; logic err; int cyc;} exp_t;

    logic CLK = 0, rst = 0, req_valid = 0, req_write = 0, rsp_ready = 1;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [15:0] tv;
    logic sv[2], s_ready[2], s_valid[2], s_err[2];
    logic [31:0] s_rdata[2];
    logic [15:0] s_tv[2];

    exp_t sbq[$];
    logic [31:0] model[64];
    int n_cmp = 0, n_fail = 0, cyc = 0;
    logic prev_v = 0;

    data_mem_responder #(.LATENCY(LAT)) dut (
        .CLK(CLK), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .testValue(tv));
    data_mem_responder #(.LATENCY(0)) dut_l0 (
        .CLK(CLK), .rst(rst), .req_valid(sv[0]), .req_ready(s_ready[0]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(s_valid[0]), .rsp_ready(1'b1), .rsp_rdata(s_rdata[0]),
        .rsp_err(s_err[0]), .testValue(s_tv[0]));
    data_mem_responder #(.LATENCY(15)) dut_l15 (
        .CLK(CLK), .rst(rst), .req_valid(sv[1]), .req_ready(s_ready[1]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(s_valid[1]), .rsp_ready(1'b1), .rsp_rdata(s_rdata[1]),
        .rsp_err(s_err[1]), .testValue(s_tv[1]));

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: a word array addressed by byte address / 4, erroring on misalignment or range.
    function automatic exp_t ref_access(input logic w, input logic [31:0] a, input logic [31:0] d, input int c);
        exp_t e;
        bit bad = (a % 4 != 0) || (a / 4 >= 64);
        e.err = bad;
        e.rdata = 0;
        e.cyc = c;
        if (!bad) begin
            if (w) model[a / 4] = d;
            else e.rdata = model[a / 4];
        end
        return e;
    endfunction

    always @(negedge CLK) begin
        if (rst && rsp_valid) begin
            if (sbq.size() == 0) chk("unexpected_rsp", 1, 0);
            else begin
                if (!prev_v) chk("rsp_latency", cyc, sbq[0].cyc);
                chk("rsp_rdata", rsp_rdata, sbq[0].rdata);
                chk("rsp_err", rsp_err, sbq[0].err);
                chk("req_ready_busy", req_ready, 0);
                chk("testValue", tv, model[0][15:0]);
                if (rsp_ready) void'(sbq.pop_front());
            end
        end
        prev_v = rst && rsp_valid;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 100) begin step(); n++; end
        if (!req_ready) chk("req_ready_timeout", 0, 1);
    endtask

    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d, input int bp);
        int n = 0;
        wait_ready();
        req_write = w; req_addr = a; req_wdata = d; req_valid = 1; rsp_ready = (bp == 0);
        step();
        sbq.push_back(ref_access(w, a, d, cyc + 1 + LAT));
        req_valid = 0; req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        if (bp > 0) begin
            while (!rsp_valid && n < 100) begin step(); n++; end
            repeat (bp) step();
            rsp_ready = 1;
        end
        n = 0;
        while (sbq.size() != 0 && n < 100) begin step(); n++; end
        if (sbq.size() != 0) begin
            chk("rsp_timeout", sbq.size(), 0);
            sbq.delete();
        end
    endtask

    task automatic sweep(input int idx, input int lat, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp_rd);
        int k, n = 0;
        req_write = w; req_addr = a; req_wdata = d; sv[idx] = 1;
        step();
        sv[idx] = 0;
        k = cyc;
        while (!s_valid[idx] && n < 40) begin step(); n++; end
        chk("sweep_latency", cyc - k, lat + 1);
        chk("sweep_rdata", s_rdata[idx], exp_rd);
        chk("sweep_err", s_err[idx], 0);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int kind;
        logic [31:0] a, d;
        sv[0] = 0; sv[1] = 0;
        for (int i = 0; i < 64; i++) model[i] = 0;
        repeat (3) begin
            @(negedge CLK);
            chk("reset_req_ready", req_ready, 0);
            chk("reset_rsp_valid", rsp_valid, 0);
        end
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_rsp_err", rsp_err, 0);
        chk("reset_testValue", tv, 0);
        step();
        rst = 1;
        @(negedge CLK);
        chk("ready_after_reset", req_ready, 1);
        step();
        do_req(1, 32'h0, 32'hDEADBEEF, 0);
        chk("testValue_store", tv, 16'hBEEF);
        do_req(0, 32'h0, 0, 0);
        do_req(1, 32'h4, 32'h12345678, 0);
        do_req(0, 32'h4, 0, 5);
        chk("idle_after_bp", req_ready, 1);
        do_req(1, 32'h2, 32'h0BAD0BAD, 0);
        chk("err_store_mem0", tv, 16'hBEEF);
        do_req(0, 32'h100, 0, 0);
        do_req(0, 32'hFC, 0, 0);
        do_req(1, 32'h4000_0000, 32'h55AA55AA, 0);
        do_req(0, 32'h0, 0, 0);
        wait_ready();
        req_write = 1; req_addr = 32'h8; req_wdata = 32'hA5A5A5A5; req_valid = 1;
        step();
        req_valid = 0;
        step();
        rst = 0;
        for (int i = 0; i < 64; i++) model[i] = 0;
        sbq.delete();
        #1;
        chk("midreset_rsp_valid", rsp_valid, 0);
        chk("midreset_testValue", tv, 0);
        step();
        step();
        rst = 1;
        step();
        do_req(0, 32'h8, 0, 0);
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 3);
            a = 32'($urandom_range(0, 63)) * 4;
            if (kind == 2) a = a | 32'($urandom_range(1, 3));
            if (kind == 3) a = $urandom | 32'h100;
            d = $urandom;
            do_req(1'($urandom_range(0, 1)), a, d, $urandom_range(0, 3));
        end
        d = $urandom;
        sweep(0, 0, 1, 32'h20, d, 0);
        sweep(0, 0, 0, 32'h20, 0, d);
        d = $urandom;
        sweep(1, 15, 1, 32'hFC, d, 0);
        sweep(1, 15, 0, 32'hFC, 0, d);
        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
